// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline stages and pipe_ctrl.
// master = pipeline side, slave = controller side.
interface pipe_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 stallreq_if;
  logic                 stallreq_id;
  logic                 stallreq_ex;
  logic                 stallreq_mem;
  logic                 branch_req;
  logic [PC_WIDTH-1:0]  branch_target;
  logic                 trap_req;
  logic [PC_WIDTH-1:0]  trap_vector;
  logic                 branch_ack;
  logic                 trap_ack;
  logic [4:0]           stall;
  logic [4:0]           flush;
  logic [PC_WIDTH-1:0]  new_pc;
  logic                 new_pc_valid;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output stallreq_if, stallreq_id,
    output stallreq_ex, stallreq_mem,
    output branch_req, branch_target,
    output trap_req, trap_vector,
    input  branch_ack, trap_ack,
    input  stall, flush,
    input  new_pc, new_pc_valid,
    input  timeout, stall_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id,
    input  stallreq_ex, stallreq_mem,
    input  branch_req, branch_target,
    input  trap_req, trap_vector,
    output branch_ack, trap_ack,
    output stall, flush,
    output new_pc, new_pc_valid,
    output timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline,
// with registered PC redirect, stall watchdog and stall-cycle counter.
module pipe_ctrl #(
  parameter int PC_WIDTH      = 32,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_TRAP  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  logic [1:0]           r_state;
  logic [PC_WIDTH-1:0]  r_new_pc;
  logic                 r_new_pc_valid;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [WD_W-1:0]      r_wdog;

  logic [4:0] w_stall;
  logic [4:0] w_flush;
  logic       w_branch_ack;
  logic       w_trap_ack;
  logic       w_stalled;
  logic       w_wd_fire;

  always_comb begin
    w_stall      = '0;
    w_flush      = '0;
    w_branch_ack = 1'b0;
    w_trap_ack   = 1'b0;
    if (rst) begin
      unique case (r_state)
        S_RUN: begin
          if (bus.stallreq_mem) begin
            w_stall = 5'b01111;
            w_flush = 5'b10000;
          end else if (bus.stallreq_ex) begin
            w_stall = 5'b00111;
            w_flush = 5'b01000;
          end else if (bus.stallreq_id) begin
            w_stall = 5'b00011;
            w_flush = 5'b00100;
          end else if (bus.stallreq_if) begin
            w_stall = 5'b00001;
            w_flush = 5'b00010;
          end
          // Redirects wait until the data bus is ready; trap beats branch.
          if (!bus.stallreq_mem) begin
            if (bus.trap_req) begin
              w_trap_ack = 1'b1;
              w_flush    = w_flush | 5'b01110;
              w_stall    = w_stall & ~5'b01110;
            end else if (bus.branch_req) begin
              w_branch_ack = 1'b1;
              w_flush      = w_flush | 5'b00110;
              w_stall      = w_stall & ~5'b00110;
            end
          end
        end
        S_TRAP, S_REDIR: w_flush = 5'b00010;
        S_HALT:          w_stall = 5'b11111;
        default: ;
      endcase
    end
  end

  assign w_stalled = w_stall[0];
  assign w_wd_fire = w_stalled && (r_state != S_HALT)
                  && (r_wdog == WD_W'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_RUN;
      r_new_pc       <= '0;
      r_new_pc_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_stall_cnt    <= '0;
      r_wdog         <= '0;
    end else begin
      r_new_pc_valid <= 1'b0;
      if (w_stalled && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!w_stalled)
        r_wdog <= '0;
      else if (r_state != S_HALT)
        r_wdog <= r_wdog + 1'b1;
      if (w_wd_fire) begin
        r_timeout <= 1'b1;
        r_state   <= S_HALT;
      end else begin
        unique case (r_state)
          S_RUN: begin
            if (w_trap_ack) begin
              r_state        <= S_TRAP;
              r_new_pc       <= bus.trap_vector;
              r_new_pc_valid <= 1'b1;
            end else if (w_branch_ack) begin
              r_state        <= S_REDIR;
              r_new_pc       <= bus.branch_target;
              r_new_pc_valid <= 1'b1;
            end
          end
          S_TRAP, S_REDIR: r_state <= S_RUN;
          S_HALT:          r_state <= S_HALT;
          default:         r_state <= S_RUN;
        endcase
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.branch_ack   = w_branch_ack;
  assign bus.trap_ack     = w_trap_ack;
  assign bus.new_pc       = r_new_pc;
  assign bus.new_pc_valid = r_new_pc_valid;
  assign bus.timeout      = r_timeout;
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, redirects,
// trap/branch arbitration, watchdog HALT, saturation and async reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(5)) bus ();

  pipe_ctrl #(
    .PC_WIDTH(32),
    .STALL_TIMEOUT(8),
    .CNT_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stallreq_if   = 1'b0;
    bus.stallreq_id   = 1'b0;
    bus.stallreq_ex   = 1'b0;
    bus.stallreq_mem  = 1'b0;
    bus.branch_req    = 1'b0;
    bus.trap_req      = 1'b0;
  endtask

  initial begin
    idle();
    bus.branch_target = '0;
    bus.trap_vector   = '0;
    bus.stallreq_mem  = 1'b1;
    bus.branch_req    = 1'b1;
    #1;
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_back", 32'(bus.branch_ack), 32'h0);
    check("rst_npv", 32'(bus.new_pc_valid), 32'h0);
    check("rst_npc", bus.new_pc, 32'h0);
    check("rst_to", 32'(bus.timeout), 32'h0);
    check("rst_cnt", 32'(bus.stall_cnt), 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;

    // T1
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t1_stall", 32'(bus.stall), 32'h0);
      check("t1_flush", 32'(bus.flush), 32'h0);
    end
    check("t1_cnt", 32'(bus.stall_cnt), 32'd0);

    // T2
    bus.stallreq_ex = 1'b1;
    bus.stallreq_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall", 32'(bus.stall), 32'h07);
      check("t2_flush", 32'(bus.flush), 32'h08);
      cyc();
    end
    check("t2_cnt", 32'(bus.stall_cnt), 32'd3);
    idle();
    cyc();

    // id-only priority case
    bus.stallreq_id = 1'b1;
    bus.stallreq_if = 1'b1;
    #1;
    check("id_stall", 32'(bus.stall), 32'h03);
    check("id_flush", 32'(bus.flush), 32'h04);
    cyc();
    idle();
    cyc();
    check("id_cnt", 32'(bus.stall_cnt), 32'd4);

    // T3
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0100;
    bus.stallreq_mem  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_back_hold", 32'(bus.branch_ack), 32'h0);
      check("t3_mstall", 32'(bus.stall), 32'h0f);
      check("t3_mflush", 32'(bus.flush), 32'h10);
      cyc();
    end
    bus.stallreq_mem = 1'b0;
    #1;
    check("t3_back", 32'(bus.branch_ack), 32'h1);
    check("t3_flush", 32'(bus.flush), 32'h06);
    check("t3_stall", 32'(bus.stall), 32'h0);
    cyc();
    bus.branch_req = 1'b0;
    #1;
    check("t3_npc", bus.new_pc, 32'h100);
    check("t3_npv", 32'(bus.new_pc_valid), 32'h1);
    check("t3_rflush", 32'(bus.flush), 32'h02);
    cyc();
    check("t3_npv_off", 32'(bus.new_pc_valid), 32'h0);
    check("t3_cnt", 32'(bus.stall_cnt), 32'd6);

    // T4
    bus.trap_req      = 1'b1;
    bus.trap_vector   = 32'h0000_0004;
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0200;
    bus.stallreq_ex   = 1'b1;
    #1;
    check("t4_tack", 32'(bus.trap_ack), 32'h1);
    check("t4_back", 32'(bus.branch_ack), 32'h0);
    check("t4_flush", 32'(bus.flush), 32'h0e);
    check("t4_stall", 32'(bus.stall), 32'h01);
    cyc();
    bus.trap_req    = 1'b0;
    bus.stallreq_ex = 1'b0;
    #1;
    check("t4_npc", bus.new_pc, 32'h4);
    check("t4_npv", 32'(bus.new_pc_valid), 32'h1);
    check("t4_ign", 32'(bus.branch_ack), 32'h0);
    check("t4_tflush", 32'(bus.flush), 32'h02);
    cyc();
    check("t4_back2", 32'(bus.branch_ack), 32'h1);
    check("t4_flush2", 32'(bus.flush), 32'h06);
    cyc();
    bus.branch_req = 1'b0;
    check("t4_npc2", bus.new_pc, 32'h200);
    check("t4_npv2", 32'(bus.new_pc_valid), 32'h1);
    cyc();

    // T6
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0300;
    #1;
    check("t6_back", 32'(bus.branch_ack), 32'h1);
    cyc();
    bus.branch_req = 1'b0;
    check("t6_npv", 32'(bus.new_pc_valid), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_npv_rst", 32'(bus.new_pc_valid), 32'h0);
    check("t6_npc_rst", bus.new_pc, 32'h0);
    check("t6_flush_rst", 32'(bus.flush), 32'h0);
    check("t6_cnt_rst", 32'(bus.stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("t6_npv_post", 32'(bus.new_pc_valid), 32'h0);
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0008;
    #1;
    check("t6_run", 32'(bus.branch_ack), 32'h1);
    cyc();
    bus.branch_req = 1'b0;
    check("t6_npc", bus.new_pc, 32'h8);
    cyc();

    // T5
    bus.stallreq_if = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t5_stall", 32'(bus.stall), 32'h01);
      check("t5_to_pre", 32'(bus.timeout), 32'h0);
      cyc();
    end
    check("t5_to", 32'(bus.timeout), 32'h1);
    check("t5_halt", 32'(bus.stall), 32'h1f);
    check("t5_hflush", 32'(bus.flush), 32'h0);
    check("t5_cnt", 32'(bus.stall_cnt), 32'd8);
    bus.stallreq_if = 1'b0;
    bus.branch_req  = 1'b1;
    #1;
    check("t5_hback", 32'(bus.branch_ack), 32'h0);
    for (int i = 0; i < 30; i++) cyc();
    check("t5_persist", 32'(bus.stall), 32'h1f);
    check("t5_sat", 32'(bus.stall_cnt), 32'd31);
    check("t5_to2", 32'(bus.timeout), 32'h1);
    bus.branch_req = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_stall", 32'(bus.stall), 32'h0);
    check("t5_rst_to", 32'(bus.timeout), 32'h0);
    check("t5_rst_cnt", 32'(bus.stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("t5_post", 32'(bus.stall), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
